// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding, reset PC and the
// instruction value presented before the first fetch completes.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, FAULT} fetchState_e;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    localparam logic [15:0] NOP_INSTR        = 16'h0000;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read port: req/addr from the fetch unit, ack/rdata back from memory.
interface pc_fetch_unit_if #(parameter int WIDTH = 16);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_fetch_unit_watchdog.sv
// Fetch watchdog: counts FETCH cycles without ack; expired flags the TIMEOUT-th such cycle.
// Instantiated by pc_fetch_unit only when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of already-elapsed FETCH cycles, so the current cycle is cnt+1
    assign expired = active && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      cnt <= '0;
        else if (!active)  cnt <= '0;
        else if (!expired) cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, reads imem at pc via req/ack, holds the instruction until retired.
// Optional fetch timeout / FAULT state enabled with the FETCH_TIMEOUT_EN macro.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    parameter int               TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] next_pc,
    input  logic             advance,
    pc_fetch_unit_if.master  imem,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    output logic             fetch_fault
);
    fetchState_e state;
    logic        wdExpired;

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .active  (state == FETCH),
        .expired (wdExpired)
    );
    assign fetch_fault = (state == FAULT);
`else
    assign wdExpired   = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign imem.imem_addr = pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instr         <= WIDTH'(NOP_INSTR);
            instr_valid   <= 1'b0;
            imem.imem_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state         <= FETCH;
                    imem.imem_req <= 1'b1;
                end
                FETCH: begin
                    // an ack on the terminal watchdog cycle still wins over the fault
                    if (imem.imem_ack) begin
                        instr         <= imem.imem_rdata;
                        instr_valid   <= 1'b1;
                        imem.imem_req <= 1'b0;
                        state         <= EXEC;
                    end else if (wdExpired) begin
                        imem.imem_req <= 1'b0;
                        state         <= FAULT;
                    end
                end
                EXEC: begin
                    if (advance) begin
                        pc            <= next_pc;
                        instr_valid   <= 1'b0;
                        imem.imem_req <= 1'b1;
                        state         <= FETCH;
                    end
                end
                default: begin
                    imem.imem_req <= 1'b0;
                    instr_valid   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a per-cycle reference model plus literal spot checks.
module tb_pc_fetch_unit;
    localparam int TO = 15;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] next_pc;
    logic        advance;
    logic [15:0] pc, instr;
    logic        instr_valid, fetch_fault;

    pc_fetch_unit_if #(.WIDTH(16)) imemBus ();

    pc_fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .next_pc     (next_pc),
        .advance     (advance),
        .imem        (imemBus),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = just out of reset, 1 = waiting on memory,
    // 2 = holding an instruction, 3 = dead after timeout.
    int          phase;
    int          waited;
    logic [15:0] mPc, mInstr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= 0;
            waited <= 0;
            mPc    <= 16'h0000;
            mInstr <= 16'h0000;
        end else if (phase == 0) begin
            phase  <= 1;
            waited <= 0;
        end else if (phase == 1) begin
            if (imemBus.imem_ack) begin
                mInstr <= imemBus.imem_rdata;
                phase  <= 2;
            end else if (TO_ON && waited + 1 == TO) begin
                phase <= 3;
            end else begin
                waited <= waited + 1;
            end
        end else if (phase == 2) begin
            if (advance) begin
                mPc    <= next_pc;
                phase  <= 1;
                waited <= 0;
            end
        end
    end

    bit cmpOn = 1'b0;
    always @(negedge clk) begin
        if (cmpOn) begin
            chk("m_req",   16'(imemBus.imem_req), 16'(phase == 1));
            chk("m_addr",  imemBus.imem_addr,     mPc);
            chk("m_pc",    pc,                    mPc);
            chk("m_instr", instr,                 mInstr);
            chk("m_valid", 16'(instr_valid),      16'(phase == 2));
            chk("m_fault", 16'(fetch_fault),      16'(phase == 3));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; advance = 1'b0; next_pc = 16'h0000;
        imemBus.imem_ack = 1'b0; imemBus.imem_rdata = 16'h0000;
        #2;
        chk("rst_req",   16'(imemBus.imem_req), 16'h0000);
        chk("rst_pc",    pc,                    16'h0000);
        chk("rst_instr", instr,                 16'h0000);
        chk("rst_valid", 16'(instr_valid),      16'h0000);
        chk("rst_fault", 16'(fetch_fault),      16'h0000);
        step(); step();
        cmpOn = 1'b1;

        // release with ack already high: ignored in IDLE, taken on the first FETCH cycle
        reset_n = 1'b1; imemBus.imem_ack = 1'b1; imemBus.imem_rdata = 16'h1234;
        step();
        chk("rel_req",   16'(imemBus.imem_req), 16'h0001);
        chk("rel_addr",  imemBus.imem_addr,     16'h0000);
        chk("rel_valid", 16'(instr_valid),      16'h0000);
        step();
        chk("f1_instr", instr,                 16'h1234);
        chk("f1_valid", 16'(instr_valid),      16'h0001);
        chk("f1_req",   16'(imemBus.imem_req), 16'h0000);

        imemBus.imem_ack = 1'b0; next_pc = 16'h0042; advance = 1'b1;
        step();
        chk("adv_pc",    pc,                    16'h0042);
        chk("adv_addr",  imemBus.imem_addr,     16'h0042);
        chk("adv_valid", 16'(instr_valid),      16'h0000);
        chk("adv_req",   16'(imemBus.imem_req), 16'h0001);

        // advance during FETCH must be ignored; ack arrives in the third FETCH cycle
        next_pc = 16'h0099;
        step();
        chk("dly2_req", 16'(imemBus.imem_req), 16'h0001);
        chk("dly2_pc",  pc,                    16'h0042);
        advance = 1'b0;
        step();
        chk("dly3_addr", imemBus.imem_addr, 16'h0042);
        imemBus.imem_ack = 1'b1; imemBus.imem_rdata = 16'hABCD;
        step();
        chk("dly_instr", instr, 16'hABCD);
        imemBus.imem_ack = 1'b0;
        step(); step();
        chk("hold_valid", 16'(instr_valid), 16'h0001);
        chk("hold_pc",    pc,               16'h0042);

        next_pc = 16'hFFFF; advance = 1'b1;
        step();
        chk("ffff_pc", pc, 16'hFFFF);
        advance = 1'b0; imemBus.imem_ack = 1'b1; imemBus.imem_rdata = 16'h5555;
        step();
        chk("ffff_instr", instr, 16'h5555);
        imemBus.imem_ack = 1'b0; next_pc = 16'h0000; advance = 1'b1;
        step();
        chk("wrap_addr", imemBus.imem_addr,     16'h0000);
        chk("wrap_req",  16'(imemBus.imem_req), 16'h0001);
        advance = 1'b0; imemBus.imem_ack = 1'b1; imemBus.imem_rdata = 16'h7777;
        step();
        imemBus.imem_ack = 1'b0; next_pc = 16'h0300; advance = 1'b1;
        step();
        chk("p300_pc", pc, 16'h0300);
        advance = 1'b0;
        step();

        // asynchronous reset in the middle of FETCH
        #2; reset_n = 1'b0; #1;
        chk("arst_req",   16'(imemBus.imem_req), 16'h0000);
        chk("arst_pc",    pc,                    16'h0000);
        chk("arst_valid", 16'(instr_valid),      16'h0000);
        @(posedge clk); #1;
        reset_n = 1'b1; imemBus.imem_ack = 1'b1; imemBus.imem_rdata = 16'hDEAD;
        step();
        imemBus.imem_ack = 1'b0;
        chk("late_valid", 16'(instr_valid),      16'h0000);
        chk("late_instr", instr,                 16'h0000);
        chk("late_req",   16'(imemBus.imem_req), 16'h0001);
        step();
        chk("late2_valid", 16'(instr_valid), 16'h0000);

`ifdef FETCH_TIMEOUT_EN
        // now in FETCH cycle 2; cycles 3..15 still requesting
        repeat (13) begin
            step();
            chk("to_req",   16'(imemBus.imem_req), 16'h0001);
            chk("to_fault", 16'(fetch_fault),      16'h0000);
        end
        step();
        chk("fault_flag",  16'(fetch_fault),      16'h0001);
        chk("fault_req",   16'(imemBus.imem_req), 16'h0000);
        chk("fault_valid", 16'(instr_valid),      16'h0000);
        imemBus.imem_ack = 1'b1; advance = 1'b1;
        repeat (3) step();
        chk("fault_stick", 16'(fetch_fault), 16'h0001);
        imemBus.imem_ack = 1'b0; advance = 1'b0;
        reset_n = 1'b0;
        step();
        chk("fault_clr", 16'(fetch_fault), 16'h0000);
        reset_n = 1'b1;
        step();
        repeat (14) step();
        imemBus.imem_ack = 1'b1; imemBus.imem_rdata = 16'hBEEF;
        step();
        imemBus.imem_ack = 1'b0;
        chk("edge_valid", 16'(instr_valid), 16'h0001);
        chk("edge_instr", instr,            16'hBEEF);
        chk("edge_fault", 16'(fetch_fault), 16'h0000);
`else
        repeat (20) step();
        chk("wait_req",   16'(imemBus.imem_req), 16'h0001);
        chk("wait_fault", 16'(fetch_fault),      16'h0000);
        imemBus.imem_ack = 1'b1; imemBus.imem_rdata = 16'hBEEF;
        step();
        imemBus.imem_ack = 1'b0;
        chk("wait_instr", instr,            16'hBEEF);
        chk("wait_valid", 16'(instr_valid), 16'h0001);
`endif
        step();
        cmpOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
